// File: rtl/row_prog_loader.sv
// Row configuration loader: parses a header/instruction word stream into per-core program stores, holding the row in reset until every core is loaded.
// Outputs are registered; in_ready depends on state only (open in HDR/INSTR, closed in DONE/ERROR); stalls on in_valid=0 leave all state untouched.
module row_prog_loader #(
   parameter int NCORES     = 4,
   parameter int PROG_DEPTH = 15,
   parameter int WORD_W     = 16,
   parameter int LEN_W      = 4
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 start,
   input  logic [WORD_W-1:0]                    in_data,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   output logic [NCORES*PROG_DEPTH*WORD_W-1:0]  prog,
   output logic [NCORES*LEN_W-1:0]              pLength,
   output logic [NCORES-1:0]                    stack,
   output logic                                 core_rst,
   output logic                                 done,
   output logic                                 err
);

   localparam int CI_W = (NCORES > 1) ? $clog2(NCORES) : 1;
   localparam int II_W = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1;

   typedef enum logic [1:0] {
      S_HDR   = 2'd0,
      S_INSTR = 2'd1,
      S_DONE  = 2'd2,
      S_ERROR = 2'd3
   } state_t;

   state_t                              state_q, state_d;
   logic [CI_W-1:0]                     core_idx_q, core_idx_d;
   logic [II_W-1:0]                     instr_idx_q, instr_idx_d;
   logic [LEN_W-1:0]                    len_q, len_d;

   logic [NCORES*PROG_DEPTH*WORD_W-1:0] prog_q;
   logic [NCORES*LEN_W-1:0]             plen_q;
   logic [NCORES-1:0]                   stack_q;

   logic             xfer;
   logic             clr;
   logic             wr_hdr;
   logic             wr_instr;
   logic             core_cmpl;
   logic             core_last;
   logic             instr_last;
   logic [LEN_W-1:0] hdr_len;
   logic             hdr_stk;
   logic             unused_hdr_bits;

   assign hdr_len         = in_data[LEN_W-1:0];
   assign hdr_stk         = in_data[WORD_W-1];
   assign unused_hdr_bits = ^in_data[WORD_W-2:LEN_W];

   assign in_ready   = (state_q == S_HDR) || (state_q == S_INSTR);
   assign xfer       = in_valid && in_ready;
   assign core_last  = (core_idx_q == CI_W'(NCORES - 1));
   assign instr_last = ((LEN_W'(instr_idx_q) + LEN_W'(1)) == len_q);

   always_comb begin
      state_d     = state_q;
      core_idx_d  = core_idx_q;
      instr_idx_d = instr_idx_q;
      len_d       = len_q;
      clr         = 1'b0;
      wr_hdr      = 1'b0;
      wr_instr    = 1'b0;
      core_cmpl   = 1'b0;

      case (state_q)
         S_HDR: begin
            if (xfer) begin
               wr_hdr = 1'b1;
               // Oversized length still records the header so the host can see what it sent.
               if (int'(hdr_len) > PROG_DEPTH) begin
                  state_d = S_ERROR;
               end else if (hdr_len == '0) begin
                  core_cmpl = 1'b1;
               end else begin
                  len_d       = hdr_len;
                  instr_idx_d = '0;
                  state_d     = S_INSTR;
               end
            end
         end
         S_INSTR: begin
            if (xfer) begin
               wr_instr = 1'b1;
               if (instr_last) begin
                  core_cmpl = 1'b1;
               end else begin
                  instr_idx_d = instr_idx_q + II_W'(1);
               end
            end
         end
         S_DONE, S_ERROR: begin
            if (start) begin
               clr         = 1'b1;
               state_d     = S_HDR;
               core_idx_d  = '0;
               instr_idx_d = '0;
            end
         end
         default: state_d = S_HDR;
      endcase

      if (core_cmpl) begin
         if (core_last) begin
            state_d = S_DONE;
         end else begin
            core_idx_d = core_idx_q + CI_W'(1);
            state_d    = S_HDR;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_HDR;
         core_idx_q  <= '0;
         instr_idx_q <= '0;
         len_q       <= '0;
      end else begin
         state_q     <= state_d;
         core_idx_q  <= core_idx_d;
         instr_idx_q <= instr_idx_d;
         len_q       <= len_d;
      end
   end

   // Unwritten slots must read zero, so a fresh load always starts from a cleared store.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         prog_q  <= '0;
         plen_q  <= '0;
         stack_q <= '0;
      end else begin
         for (int c = 0; c < NCORES; c++) begin
            if (wr_hdr && (core_idx_q == CI_W'(c))) begin
               plen_q[c*LEN_W +: LEN_W] <= hdr_len;
               stack_q[c]               <= hdr_stk;
            end
            for (int i = 0; i < PROG_DEPTH; i++) begin
               if (wr_instr && (core_idx_q == CI_W'(c)) && (instr_idx_q == II_W'(i))) begin
                  prog_q[(c*PROG_DEPTH+i)*WORD_W +: WORD_W] <= in_data;
               end
            end
         end
      end
   end

   assign prog     = prog_q;
   assign pLength  = plen_q;
   assign stack    = stack_q;
   assign core_rst = (state_q != S_DONE);
   assign done     = (state_q == S_DONE);
   assign err      = (state_q == S_ERROR);

endmodule

// File: tb/tb_row_prog_loader.sv
// Directed bench for row_prog_loader: a default instance plus a PROG_DEPTH=14 instance on shared inputs
// (the latter exercises the oversize-length error path); expected stores are built from the driven stream.
module tb_row_prog_loader;

   localparam int NC   = 4;
   localparam int PD   = 15;
   localparam int PD_B = 14;
   localparam int W    = 16;
   localparam int LW   = 4;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic               in_valid;
   logic [W-1:0]       in_data;

   logic               rdy_a, crst_a, done_a, err_a;
   logic [NC*PD*W-1:0] prog_a;
   logic [NC*LW-1:0]   plen_a;
   logic [NC-1:0]      stk_a;

   logic                 rdy_b, crst_b, done_b, err_b;
   logic [NC*PD_B*W-1:0] prog_b;
   logic [NC*LW-1:0]     plen_b;
   logic [NC-1:0]        stk_b;

   always #5 clk = ~clk;

   row_prog_loader #(.NCORES(NC), .PROG_DEPTH(PD), .WORD_W(W), .LEN_W(LW)) dut_a (
      .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy_a), .prog(prog_a), .pLength(plen_a), .stack(stk_a),
      .core_rst(crst_a), .done(done_a), .err(err_a));

   row_prog_loader #(.NCORES(NC), .PROG_DEPTH(PD_B), .WORD_W(W), .LEN_W(LW)) dut_b (
      .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy_b), .prog(prog_b), .pLength(plen_b), .stack(stk_b),
      .core_rst(crst_b), .done(done_b), .err(err_b));

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   bit rnd         = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   logic [W-1:0]  exp_prog [NC][PD];
   logic [LW-1:0] exp_len  [NC];
   logic [NC-1:0] exp_stk;

   typedef struct {
      int           c;
      int           i;
      logic [W-1:0] v;
   } wr_t;
   wr_t sb[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [NC*LW-1:0] exp_plen_vec();
      logic [NC*LW-1:0] v;
      for (int c = 0; c < NC; c++) v[c*LW +: LW] = exp_len[c];
      return v;
   endfunction

   task automatic clear_exp();
      for (int c = 0; c < NC; c++) begin
         exp_len[c] = '0;
         for (int i = 0; i < PD; i++) exp_prog[c][i] = '0;
      end
      exp_stk = '0;
      sb.delete();
   endtask

   task automatic idle_check();
      chk("idle_plen", plen_a, exp_plen_vec());
      chk("idle_stack", stk_a, exp_stk);
   endtask

   task automatic send(input logic [W-1:0] w);
      int t;
      if (rnd) begin
         for (int k = 0; k < 3 && $urandom_range(0, 1) == 1; k++) begin
            in_valid = 1'b0;
            in_data  = W'($urandom);
            @(posedge clk); #1;
            idle_check();
         end
      end
      in_data  = w;
      in_valid = 1'b1;
      t = 0;
      while (rdy_a !== 1'b1 && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 100) chk("ready_timeout", rdy_a, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic hdr(input int c, input logic [W-1:0] w);
      send(w);
      exp_len[c] = w[LW-1:0];
      exp_stk[c] = w[W-1];
   endtask

   task automatic instr(input int c, input int i, input logic [W-1:0] w);
      sb.push_back('{c, i, w});
      send(w);
      exp_prog[c][i] = w;
   endtask

   task automatic check_image(input string tag);
      wr_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, "_sb_prog"}, prog_a[(e.c*PD+e.i)*W +: W], e.v);
      end
      for (int c = 0; c < NC; c++)
         for (int i = 0; i < PD; i++)
            chk({tag, "_prog"}, prog_a[(c*PD+i)*W +: W], exp_prog[c][i]);
      chk({tag, "_plen"}, plen_a, exp_plen_vec());
      chk({tag, "_stack"}, stk_a, exp_stk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // A valid word is presented while rst is high; reset must win over the transfer.
   task automatic do_reset();
      rst      = 1'b1;
      in_valid = 1'b1;
      in_data  = 16'h8003;
      repeat (2) @(posedge clk);
      #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      clear_exp();
   endtask

   task automatic stream1();
      hdr(0, 16'h0002);
      instr(0, 0, 16'h1111);
      instr(0, 1, 16'h2222);
      hdr(1, 16'h8001);
      instr(1, 0, 16'h3333);
      hdr(2, 16'h0000);
      hdr(3, 16'h0003);
      instr(3, 0, 16'h4444);
      instr(3, 1, 16'h5555);
      chk("pre_last_done", done_a, 0);
      chk("pre_last_core_rst", crst_a, 1);
      instr(3, 2, 16'h6666);
   endtask

   task automatic check_cleared(input string tag);
      chk({tag, "_prog_zero"}, (prog_a == '0), 1);
      chk({tag, "_plen"}, plen_a, 0);
      chk({tag, "_stack"}, stk_a, 0);
      chk({tag, "_done"}, done_a, 0);
      chk({tag, "_core_rst"}, crst_a, 1);
      chk({tag, "_ready"}, rdy_a, 1);
   endtask

   initial begin
      int c0;
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
      clear_exp();

      do_reset();
      check_cleared("reset");
      chk("reset_err", err_a, 0);

      // In-order stream, in_valid held high: 10 transfers, done one edge after the last.
      c0 = cyc;
      stream1();
      chk("t1_cycles", 64'(cyc - c0), 10);
      chk("t1_done", done_a, 1);
      chk("t1_core_rst", crst_a, 0);
      chk("t1_ready", rdy_a, 0);
      chk("t1_err", err_a, 0);
      check_image("t1");
      chk("t1_prog_0_0", prog_a[0*W +: W], 16'h1111);
      chk("t1_prog_1_0", prog_a[(1*PD+0)*W +: W], 16'h3333);
      chk("t1_prog_3_2", prog_a[(3*PD+2)*W +: W], 16'h6666);
      chk("t1_b_done", done_b, 1);

      // DONE ignores further traffic.
      in_valid = 1'b1; in_data = 16'h8009;
      repeat (3) @(posedge clk);
      #1;
      in_valid = 1'b0;
      check_image("done_hold");
      chk("done_hold_done", done_a, 1);

      pulse_start();
      clear_exp();
      check_cleared("start_done");

      // Same stream with random idle cycles between words.
      rnd = 1'b1;
      stream1();
      rnd = 1'b0;
      chk("t2_done", done_a, 1);
      check_image("t2");

      pulse_start();
      clear_exp();

      // Full-depth core 0 then zero-length cores; the depth-14 instance must error on L=15.
      hdr(0, 16'h000F);
      chk("b_err", err_b, 1);
      chk("b_ready", rdy_b, 0);
      chk("b_core_rst", crst_b, 1);
      chk("b_plen0", plen_b[LW-1:0], 15);
      chk("a_not_err", err_a, 0);
      for (int i = 0; i < PD; i++) instr(0, i, 16'hA000 + 16'(i));
      hdr(1, 16'h0000);
      hdr(2, 16'h0000);
      hdr(3, 16'h0000);
      chk("t3_done", done_a, 1);
      chk("t3_prog_0_14", prog_a[14*W +: W], 16'hA00E);
      chk("t4_plen1", plen_a[1*LW +: LW], 0);
      check_image("t3");
      chk("b_err_held", err_b, 1);
      chk("b_prog_untouched", (prog_b == '0), 1);

      pulse_start();
      clear_exp();
      chk("b_err_cleared", err_b, 0);
      chk("b_ready_again", rdy_b, 1);
      chk("b_core_rst_start", crst_b, 1);

      // Zero-length core followed by a stack-only core.
      hdr(0, 16'h0000);
      hdr(1, 16'h8000);
      hdr(2, 16'h0001);
      instr(2, 0, 16'hBEEF);
      hdr(3, 16'h0000);
      chk("t5_done", done_a, 1);
      chk("t5_b_done", done_b, 1);
      chk("t5_b_err", err_b, 0);
      chk("t5_stack", stk_a, 4'b0010);
      check_image("t5");

      pulse_start();
      clear_exp();

      // start mid-load is ignored.
      hdr(0, 16'h0001);
      pulse_start();
      chk("start_ignored_plen", plen_a[LW-1:0], 1);
      chk("start_ignored_ready", rdy_a, 1);
      instr(0, 0, 16'h7777);
      hdr(1, 16'h0000);
      hdr(2, 16'h0002);
      check_image("pre_rst");

      // rst after core 2 header discards everything and restarts at core 0.
      do_reset();
      check_cleared("mid_rst");
      stream1();
      chk("after_rst_done", done_a, 1);
      check_image("after_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/row_prog_loader.md
Name: row_prog_loader

Overview:
- Configuration controller for one row of TIS cores.
- Accepts a word stream over a valid/ready handshake and writes each core's program memory, program length and stack flag.
- Holds the row in reset while loading and releases it once every core is configured.
- Sits between the host/boot source and the row, replacing file-initialised program arrays in synthesis builds.

Parameters:
NCORES, 4, number of cores in the row
PROG_DEPTH, 15, instruction slots per core
WORD_W, 16, instruction/stream word width
LEN_W, 4, width of per-core program length field

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; re-arms a load from DONE or ERROR
in_data  input  WORD_W  stream word
in_valid  input  1  in_data valid
in_ready  output  1  loader accepts word this cycle
prog  output  NCORES*PROG_DEPTH*WORD_W  flattened program store; entry (c,i) at bits [(c*PROG_DEPTH+i)*WORD_W +: WORD_W]
pLength  output  NCORES*LEN_W  per-core length; core c at [c*LEN_W +: LEN_W]
stack  output  NCORES  per-core stack-node flag
core_rst  output  1  reset to row; high except in DONE
done  output  1  high in DONE
err  output  1  high in ERROR

Behaviour:
- Transfer occurs on a rising edge with in_valid & in_ready. in_ready is combinational from state only: 1 in HDR/INSTR, 0 in DONE/ERROR. There is no dependence on in_valid.
- State reg values: HDR, INSTR, DONE, ERROR. Counters: core_idx (0..NCORES-1) and instr_idx (0..PROG_DEPTH-1). Latched target length: len_r.
- Reset (rst=1 at edge):
  - state=HDR, core_idx=0, instr_idx=0.
  - All prog entries, pLength and stack are 0.
  - core_rst=1, done=0, err=0.
  - Loading begins in the first cycle after rst falls; no start is needed.
- Header word (HDR): bit WORD_W-1 is the stack flag; bits [LEN_W-1:0] are the length L; other bits are ignored.
  - On transfer, stack[core_idx] and pLength[core_idx] are written.
  - L > PROG_DEPTH: go to ERROR. pLength/stack for that core are still written. prog is left untouched.
  - L = 0: this core is complete. If core_idx = NCORES-1, go to DONE; otherwise core_idx+1 and stay in HDR.
  - Otherwise: len_r=L, instr_idx=0, go to INSTR.
- Instruction word (INSTR): on transfer, prog[core_idx][instr_idx]=in_data.
  - If instr_idx = len_r-1, the core is complete; next state follows the same rule as L=0.
  - Otherwise instr_idx+1.
- Slots beyond L keep 0 (cleared at reset/start).
- Stalls: with in_valid=0, nothing changes; any number of idle cycles is allowed between words.
- Outputs are registered. The final word accepted at edge N gives done=1 and core_rst=0 after edge N; the row sees its first non-reset cycle at N+1.
- DONE: arrays hold. in_valid is ignored (in_ready=0).
- ERROR: core_rst=1, err=1, stream blocked. Only start or rst exits.
- start:
  - Honoured only in DONE or ERROR. It clears all prog/pLength/stack, sets core_idx=0, state=HDR, core_rst=1, done=0, err=0 at that edge.
  - Ignored in HDR/INSTR (the load is not restarted).
- rst has priority over start and over transfers in the same cycle.
- rst mid-load discards partial contents (all cleared) and restarts at core 0 header.
- Word count for a complete load = NCORES + sum(L_c).
- Max PROG_DEPTH must be < 2^LEN_W.

Test Plan:
1. Reset, then stream headers 0x0002, 0x8001, 0x0000, 0x0003 with instructions 0x1111, 0x2222 | 0x3333 | - | 0x4444, 0x5555, 0x6666, in_valid held high → 10 transfers. Then pLength={2,1,0,3}, stack={0,1,0,0}, prog(0,0)=0x1111, prog(1,0)=0x3333, prog(3,2)=0x6666, all other slots 0. done=1 and core_rst=0 exactly one edge after the 10th transfer.
2. Same stream with in_valid toggled pseudo-randomly → identical final contents. No state change on in_valid=0 cycles.
3. Header 0x000F (L=15) for core 0 → 15 instructions accepted; prog(0,14) holds the last word. Header 0x0000 for cores 1-3 → done.
4. Core 1 header length 0x0 → next word is treated as core 2 header; verify core 1 prog all 0 and pLength[1]=0.
5. Header 0x0000 then 0x8000 → core 1 pLength=0, stack=1.
6. Core 0 header L=0xF with PROG_DEPTH=14 → err=1, in_ready=0, core_rst=1. A start pulse, then a valid full stream → done=1, err=0. Assert rst after core 2 header (rst mid-load) → arrays all 0, state HDR, core_idx 0.
